// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to imem over req/ready,
// holds the returned instruction in the IR and applies redirects and flushes.
module fetch_stage #(
  parameter int unsigned      DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'hBFC00000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  PCsrc,
  input  logic                  JALRsrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [DATA_WIDTH-1:0] ALUresult,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] flush_target,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

  logic                  consume;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] target;

  // Handshake, redirect target and request outputs
  always_comb begin
    consume  = instr_valid_q & ~stall;
    redirect = consume & (PCsrc | JALRsrc);
    if (JALRsrc) begin
      target = ALUresult & ~ONE;
    end else begin
      target = pc_q + ImmExt;
    end
    imem_addr = redirect ? target : fetch_pc_q;
    imem_req  = ~rst & (state_q == FETCH) & ~flush
              & (~instr_valid_q | consume);
  end

  // Next-state and IR update; flush overrides redirect and consume
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;

    if (consume | flush) begin
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
    end

    unique case (state_q)
      FETCH: begin
        if (flush) begin
          fetch_pc_d = flush_target;
        end else if (imem_req && imem_ready) begin
          req_pc_d   = imem_addr;
          fetch_pc_d = imem_addr + FOUR;
          state_d    = WAIT;
        end else if (redirect) begin
          fetch_pc_d = target;
        end
      end
      WAIT: begin
        if (flush) begin
          fetch_pc_d = flush_target;
          state_d    = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          pc_d          = req_pc_q;
          pc_plus4_d    = req_pc_q + FOUR;
          state_d       = FETCH;
        end
      end
      DROP: begin
        if (flush) begin
          fetch_pc_d = flush_target;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + FOUR;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, branch, JALR,
// stall, flush in WAIT and reset mid-transaction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        PCsrc;
  logic        JALRsrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUresult;
  logic        flush;
  logic [31:0] flush_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .PCsrc       (PCsrc),
    .JALRsrc     (JALRsrc),
    .ImmExt      (ImmExt),
    .ALUresult   (ALUresult),
    .flush       (flush),
    .flush_target(flush_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; PCsrc = 0; JALRsrc = 0;
    ImmExt = 0; ALUresult = 0; flush = 0; flush_target = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;

    // 1. reset
    tick(); tick();
    chk("req_in_rst", {31'd0, imem_req}, 32'd0);
    rst = 0; #1;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'hBFC00000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_pc", pc, 32'hBFC00000);
    chk("rst_pc4", pc_plus4, 32'hBFC00004);

    // 2. sequential fetch
    imem_ready = 1; tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h00500093; #1;
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 0; stall = 1; #1;
    chk("seq_valid", {31'd0, instr_valid}, 32'd1);
    chk("seq_instr", instr, 32'h00500093);
    chk("seq_pc", pc, 32'hBFC00000);
    chk("seq_pc4", pc_plus4, 32'hBFC00004);
    chk("seq_addr", imem_addr, 32'hBFC00004);

    // 5. stall holds IR, no request
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("stall_instr", instr, 32'h00500093);
      chk("stall_pc", pc, 32'hBFC00000);
    end
    stall = 0; #1;
    chk("unstall_req", {31'd0, imem_req}, 32'd1);

    // consume without capture empties IR
    imem_ready = 1; tick();
    imem_ready = 0; #1;
    chk("cons_valid", {31'd0, instr_valid}, 32'd0);
    chk("cons_instr", instr, 32'h00000013);
    imem_rvalid = 1; imem_rdata = 32'h00100113; tick();
    imem_rvalid = 0; #1;
    chk("seq2_pc", pc, 32'hBFC00004);
    imem_ready = 1; tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h00000063; tick();
    imem_rvalid = 0; #1;
    chk("seq3_pc", pc, 32'hBFC00008);
    chk("seq3_instr", instr, 32'h00000063);

    // 3. branch back by 8, memory not ready for 2 cycles
    PCsrc = 1; ImmExt = 32'hFFFFFFF8; #1;
    chk("br_addr", imem_addr, 32'hBFC00000);
    tick();
    PCsrc = 0; ImmExt = 0; #1;
    chk("br_hold1", imem_addr, 32'hBFC00000);
    chk("br_req1", {31'd0, imem_req}, 32'd1);
    tick();
    chk("br_hold2", imem_addr, 32'hBFC00000);
    imem_ready = 1; tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h00000067; tick();
    imem_rvalid = 0; #1;
    chk("br_pc", pc, 32'hBFC00000);

    // 4. JALR wins over branch, low bit cleared
    JALRsrc = 1; PCsrc = 1; ImmExt = 32'd8; ALUresult = 32'h00001235; #1;
    chk("jalr_addr", imem_addr, 32'h00001234);
    imem_ready = 1; tick();
    JALRsrc = 0; PCsrc = 0; ImmExt = 0; ALUresult = 0;
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h00000013; tick();
    imem_rvalid = 0; #1;
    chk("jalr_pc", pc, 32'h00001234);
    chk("jalr_pc4", pc_plus4, 32'h00001238);
    chk("next_addr", imem_addr, 32'h00001238);

    // 6a. flush in WAIT, response arrives later
    imem_ready = 1; tick();
    imem_ready = 0; flush = 1; flush_target = 32'h80000000; tick();
    flush = 0; #1;
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1; imem_rdata = 32'hDEADBEEF; tick();
    imem_rvalid = 0; #1;
    chk("fl_valid", {31'd0, instr_valid}, 32'd0);
    chk("fl_instr", instr, 32'h00000013);
    chk("fl_req", {31'd0, imem_req}, 32'd1);
    chk("fl_addr", imem_addr, 32'h80000000);
    chk("fl_pc", pc, 32'h00001234);

    // 6b. flush and rvalid in same cycle
    imem_ready = 1; tick();
    imem_ready = 0; flush = 1; flush_target = 32'h80000100;
    imem_rvalid = 1; imem_rdata = 32'hDEADBEEF; #1;
    chk("fl2_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    flush = 0; imem_rvalid = 0; #1;
    chk("fl2_valid", {31'd0, instr_valid}, 32'd0);
    chk("fl2_instr", instr, 32'h00000013);
    chk("fl2_req", {31'd0, imem_req}, 32'd1);
    chk("fl2_addr", imem_addr, 32'h80000100);
    imem_ready = 1; tick();
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 32'h00200193; tick();
    imem_rvalid = 0; #1;
    chk("fl2_pc", pc, 32'h80000100);
    chk("fl2_cap", instr, 32'h00200193);

    // reset mid-transaction
    imem_ready = 1; tick();
    imem_ready = 0; rst = 1; tick();
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    rst = 0; #1;
    chk("mrst_addr", imem_addr, 32'hBFC00000);
    chk("mrst_req1", {31'd0, imem_req}, 32'd1);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_pc", pc, 32'hBFC00000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
